ldlt_stream_feeder: RTL and testbench

//  - Upstream feeder for the LDLT engine.
//  - Accepts one packed lower-triangular matrix from a host over a valid/ready stream and buffers it whole in an internal RAM.
//  - Then issues the gap-free launch sequence LDLT requires: a 1-cycle start pulse, followed by L_SIZE consecutive words.
//  - Tracks the LDLT output stream so that a new matrix is never launched while the previous result is still draining.

---
 rtl/ldlt_stream_feeder.sv | 170 +++++++++++++++++
 tb/tb_ldlt_stream_feeder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ldlt_stream_feeder.sv
// ---------------------------------------------------------------------------
// ldlt_stream_feeder
//
// Upstream feeder for the LDLT engine. It buffers one packed lower-triangular
// matrix received from a host over a valid/ready stream. It then launches the
// LDLT engine with a 1-cycle start pulse, followed by L_SIZE gap-free words.
// Afterwards it waits for the LDLT result stream to drain before it accepts
// the next matrix.
//
// Parameters
//   DATA_LEN  word width (fixed point, passed through bit-exact)
//   NODE_NUM  matrix order N = 6*NODE_NUM, L_SIZE = N*(N+1)/2
//
// Ports
//   clk         clock, all state on posedge
//   rst_n       asynchronous active-low reset
//   s_valid     host word valid
//   s_ready     feeder can accept a word (high exactly in LOAD)
//   s_data      host word
//   o_start     LDLT start pulse (registered)
//   o_data      LDLT input word (registered, 0 when idle)
//   ldlt_valid  LDLT first-result-word marker
//   busy        high in any state except LOAD
//   done        1-cycle pulse once the LDLT result has drained
//
// Configuration
//   FEEDER_FULL_MATRIX_EN  when defined, the host sends the full symmetric
//                          N*N matrix row-major. Only the words with
//                          col <= row are stored.
// ---------------------------------------------------------------------------
module ldlt_stream_feeder #(
  parameter int DATA_LEN = 32,
  parameter int NODE_NUM = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_LEN-1:0] s_data,
  output logic                o_start,
  output logic [DATA_LEN-1:0] o_data,
  input  logic                ldlt_valid,
  output logic                busy,
  output logic                done
);

  localparam int N      = 6 * NODE_NUM;
  localparam int L_SIZE = N * (N + 1) / 2;
  localparam int CW     = $clog2(L_SIZE + 1);

  typedef enum logic [1:0] {LOAD, START, BURST, DRAIN} state_t;

  state_t              state;
  logic [CW-1:0]       wr_cnt;   // next RAM write address
  logic [CW-1:0]       seq_cnt;  // burst read address, then drain cycle count
  logic [DATA_LEN-1:0] mem [L_SIZE];

  logic accept;     // a host word is taken on this edge
  logic wr_en;      // the accepted word belongs to the lower triangle
  logic load_last;  // the accepted word completes the matrix

  assign s_ready = (state == LOAD);
  assign busy    = (state != LOAD);
  assign accept  = s_valid && (state == LOAD);

`ifdef FEEDER_FULL_MATRIX_EN
  localparam int RCW = (N > 1) ? $clog2(N) : 1;

  logic [RCW-1:0] row;
  logic [RCW-1:0] col;

  assign wr_en     = accept && (col <= row);
  assign load_last = accept && (row == RCW'(N - 1)) && (col == RCW'(N - 1));

  // Position of the next host word in the full row-major matrix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (load_last) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col == RCW'(N - 1)) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end
`else
  assign wr_en     = accept;
  assign load_last = accept && (wr_cnt == CW'(L_SIZE - 1));
`endif

  // NOTE: the matrix RAM has no reset. Its contents are always written
  // before they are read, and leaving the reset off lets it map onto block
  // or distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_cnt] <= s_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments. This lets
  // every branch read the pre-edge values of state and the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOAD;
      wr_cnt  <= '0;
      seq_cnt <= '0;
      o_start <= 1'b0;
      o_data  <= '0;
      done    <= 1'b0;
    end else begin
      o_start <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        LOAD: begin
          if (wr_en) begin
            wr_cnt <= wr_cnt + 1'b1;
          end
          // The start pulse is raised on the same edge that stores the
          // last word, so no idle cycle is inserted.
          if (load_last) begin
            state   <= START;
            o_start <= 1'b1;
          end
        end

        START: begin
          // Prefetch word 0 so the burst begins right after the pulse.
          o_data  <= mem[0];
          seq_cnt <= CW'(1);
          state   <= BURST;
        end

        BURST: begin
          if (seq_cnt == CW'(L_SIZE)) begin
            o_data  <= '0;
            seq_cnt <= '0;
            state   <= DRAIN;
          end else begin
            o_data  <= mem[seq_cnt];
            seq_cnt <= seq_cnt + 1'b1;
          end
        end

        DRAIN: begin
          // Counting starts on the first ldlt_valid cycle and then runs
          // regardless of ldlt_valid, mirroring the contiguous result stream.
          if (ldlt_valid || (seq_cnt != '0)) begin
            if (seq_cnt == CW'(L_SIZE - 1)) begin
              done    <= 1'b1;
              state   <= LOAD;
              wr_cnt  <= '0;
              seq_cnt <= '0;
            end else begin
              seq_cnt <= seq_cnt + 1'b1;
            end
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_ldlt_stream_feeder.sv
// ---------------------------------------------------------------------------
// tb_ldlt_stream_feeder
//
// Directed self-checking bench for ldlt_stream_feeder at default parameters
// (N=6, L_SIZE=21). Inputs are driven 1 time unit after the rising edge.
// Outputs are sampled at that same point, so every sample shows the state
// of the current cycle. If FEEDER_FULL_MATRIX_EN is defined, the
// full-matrix load sequence runs instead.
// ---------------------------------------------------------------------------
module tb_ldlt_stream_feeder;

  localparam int DATA_LEN = 32;
  localparam int L_SIZE   = 21;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                s_valid;
  logic                s_ready;
  logic [DATA_LEN-1:0] s_data;
  logic                o_start;
  logic [DATA_LEN-1:0] o_data;
  logic                ldlt_valid;
  logic                busy;
  logic                done;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  ldlt_stream_feeder #(
    .DATA_LEN(DATA_LEN),
    .NODE_NUM(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .o_start   (o_start),
    .o_data    (o_data),
    .ldlt_valid(ldlt_valid),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_seq(input int base, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(base + i);
  endtask

  // Asserts reset in the middle of a cycle and checks that the outputs
  // respond without waiting for a clock edge.
  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #2;
    check({tag, "_ready"}, s_ready, 1);
    check({tag, "_start"}, o_start, 0);
    check({tag, "_data"},  o_data,  0);
    check({tag, "_busy"},  busy,    0);
    check({tag, "_done"},  done,    0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Sends values base..base+count-1, one per accepted handshake.
  task automatic push_words(input int base, input int count, input bit gap);
    for (int i = 0; i < count; i++) begin
      if (gap) begin
        s_valid = 1'b0;
        step();
      end
      s_valid = 1'b1;
      s_data  = DATA_LEN'(base + i);
      check("load_no_start", o_start, 0);
      for (int b = 0; b < 200 && !s_ready; b++) step();
      if (!s_ready) check("ready_timeout", s_ready, 1);
      step();
    end
    s_valid = 1'b0;
  endtask

  // Called in the cycle right after the last accepted word.
  task automatic check_burst(input bit noise);
    check("start_pulse", o_start, 1);
    check("start_data",  o_data,  0);
    check("start_ready", s_ready, 0);
    check("start_busy",  busy,    1);
    if (noise) ldlt_valid = 1'b1;
    for (int k = 0; k < L_SIZE; k++) begin
      step();
      check($sformatf("burst[%0d]", k), o_data, exp_q[k]);
      check("burst_no_start", o_start, 0);
    end
    step();
    ldlt_valid = 1'b0;
    check("post_burst_data", o_data, 0);
    check("post_burst_busy", busy, 1);
  endtask

  // Waits `idle` cycles in DRAIN, then raises ldlt_valid in cycle X.
  // The task returns in cycle X+21, where done is expected.
  task automatic drain(input int idle);
    for (int i = 0; i < idle; i++) begin
      check("idle_busy",  busy,    1);
      check("idle_ready", s_ready, 0);
      check("idle_done",  done,    0);
      step();
    end
    ldlt_valid = 1'b1;
    step();
    ldlt_valid = 1'b0;
    repeat (L_SIZE - 2) step();
    check("done_early", done, 0);
    check("drain_data", o_data, 0);
    step();
    check("done_pulse", done,    1);
    check("done_ready", s_ready, 1);
    check("done_busy",  busy,    0);
  endtask

  initial begin
    s_valid    = 1'b0;
    s_data     = '0;
    ldlt_valid = 1'b0;
    apply_reset("rst0");

`ifdef FEEDER_FULL_MATRIX_EN
    // Full matrix: value = row*6+col = row-major index.
    exp_q.delete();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c <= r; c++) exp_q.push_back(r * 6 + c);
    push_words(0, 36, 1'b0);
    check_burst(1'b0);
    drain(0);
    step();
    check("done_drop", done, 0);
`else
    // Back-to-back load of 1..21.
    fill_seq(1, L_SIZE);
    push_words(1, L_SIZE, 1'b0);
    check_burst(1'b0);
    drain(0);
    step();
    check("done_drop", done, 0);

    // Gapped load, with ldlt_valid noise during load and burst, and a
    // long wait for ldlt_valid.
    fill_seq(501, L_SIZE);
    ldlt_valid = 1'b1;
    push_words(501, L_SIZE, 1'b1);
    check_burst(1'b1);
    drain(50);
    step();

    // Reset mid-LOAD after 10 words, then a fresh load.
    push_words(301, 10, 1'b0);
    apply_reset("rst_load");
    fill_seq(401, L_SIZE);
    push_words(401, L_SIZE, 1'b0);
    check_burst(1'b0);
    drain(0);
    step();

    // Reset mid-BURST at k=5, then a fresh load.
    push_words(51, L_SIZE, 1'b0);
    check("k5_start", o_start, 1);
    repeat (6) step();
    check("burst_k5", o_data, 56);
    apply_reset("rst_burst");
    fill_seq(201, L_SIZE);
    push_words(201, L_SIZE, 1'b0);
    check_burst(1'b0);
    drain(0);
    step();

    // s_valid held with 30+ words available: 22.. wait until done.
    fill_seq(1, L_SIZE);
    push_words(1, L_SIZE, 1'b0);
    s_valid = 1'b1;
    s_data  = DATA_LEN'(22);
    check_burst(1'b0);
    drain(3);
    fill_seq(22, L_SIZE);
    push_words(22, L_SIZE, 1'b0);
    check_burst(1'b0);
    drain(0);
    step();
    check("done_drop2", done, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
